// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq : multi-cycle sequencer for the radix-2 restoring divider behind
//           DIV / DIVU in the execute stage.
//
// A start request latches the operands (magnitudes for signed division).
// The sequencer then runs one restoring step per clock. The result is
// returned as {HI = remainder, LO = quotient}. While the request is
// outstanding, the pipeline is held via stall_o.
//
// Ports
//   clk       in   system clock, rising edge
//   resetn    in   asynchronous active-low reset
//   start_i   in   division request, held until ready_o is seen
//   signed_i  in   1 = DIV (two's complement), 0 = DIVU; sampled with start
//   annul_i   in   flush/exception, aborts any operation (beats start_i)
//   opa_i     in   dividend (rs)
//   opb_i     in   divisor (rt)
//   result_o  out  {remainder, quotient}, updated only on entry to END
//   ready_o   out  result_o valid (state == END)
//   stall_o   out  pipeline stall request (combinational)
//
// Optional feature macro: DIV_SEQ_EARLY_EXIT_EN
//   When defined, an operation whose latched |a| < |b| finishes after the
//   first iteration edge with quotient 0 and remainder a. This also covers
//   a == 0. When undefined, every nonzero-divisor operation runs WIDTH steps.
// -----------------------------------------------------------------------------
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic                 annul_i,
  input  logic [WIDTH-1:0]     opa_i,
  input  logic [WIDTH-1:0]     opb_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 stall_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     div_q, div_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0]   res_q, res_d;

  logic [WIDTH:0]       trial_s;
  logic [WIDTH-1:0]     step_rem_s;
  logic [WIDTH-1:0]     step_quo_s;

  // Magnitude of a two's-complement value when signed, raw value otherwise.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x,
                                           input logic             is_signed);
    logic [WIDTH-1:0] r;
    if (is_signed && x[WIDTH-1]) begin
      r = (~x) + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r = x;
    end
    return r;
  endfunction

  // Conditional WIDTH-bit wrap-around negation for the sign fixup.
  function automatic logic [WIDTH-1:0] fix(input logic [WIDTH-1:0] x,
                                           input logic             neg);
    logic [WIDTH-1:0] r;
    if (neg) begin
      r = (~x) + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r = x;
    end
    return r;
  endfunction

  // One restoring step: shift {rem, quo} left and trial-subtract the divisor.
  // The extra top bit of trial_s is the borrow.
  always_comb begin
    trial_s = {rem_q, quo_q[WIDTH-1]} - {1'b0, div_q};
    if (!trial_s[WIDTH]) begin
      step_rem_s = trial_s[WIDTH-1:0];
      step_quo_s = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      step_rem_s = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
      step_quo_s = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  // Next-state and datapath update for the sequencer FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    res_d     = res_q;

    if (annul_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            // quo holds |a| and is shifted out MSB-first into rem.
            quo_d     = mag(opa_i, signed_i);
            div_d     = mag(opb_i, signed_i);
            rem_d     = '0;
            cnt_d     = '0;
            neg_quo_d = signed_i & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
            neg_rem_d = signed_i & opa_i[WIDTH-1];
            if (opb_i == '0) begin
              state_d = S_BYZERO;
            end else begin
              state_d = S_ON;
            end
          end else begin
            state_d = S_IDLE;
          end
        end

        S_BYZERO: begin
          // Divide-by-zero reports on the second edge after the start edge.
          if (cnt_q == CNT_ONE) begin
            state_d = S_END;
            cnt_d   = '0;
            res_d   = '0;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end

        S_ON: begin
`ifdef DIV_SEQ_EARLY_EXIT_EN
          // First iteration edge: a dividend smaller than the divisor is its
          // own remainder, so skip the remaining steps.
          if ((cnt_q == '0) && (quo_q < div_q)) begin
            state_d = S_END;
            cnt_d   = '0;
            res_d   = {fix(quo_q, neg_rem_q), {WIDTH{1'b0}}};
          end else begin
            rem_d = step_rem_s;
            quo_d = step_quo_s;
            if (cnt_q == CNT_LAST) begin
              state_d = S_END;
              cnt_d   = '0;
              res_d   = {fix(step_rem_s, neg_rem_q), fix(step_quo_s, neg_quo_q)};
            end else begin
              cnt_d   = cnt_q + CNT_ONE;
            end
          end
`else
          rem_d = step_rem_s;
          quo_d = step_quo_s;
          if (cnt_q == CNT_LAST) begin
            state_d = S_END;
            cnt_d   = '0;
            res_d   = {fix(step_rem_s, neg_rem_q), fix(step_quo_s, neg_quo_q)};
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
`endif
        end

        S_END: begin
          // Hold the result until the execute stage drops its request.
          if (start_i) begin
            state_d = S_END;
          end else begin
            state_d = S_IDLE;
          end
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      res_q     <= res_d;
    end
  end

  assign result_o = res_q;
  assign ready_o  = (state_q == S_END);
  // Stall drops in the cycle ready_o rises, and immediately on a flush.
  assign stall_o  = start_i & ~ready_o & ~annul_i;

endmodule

// File: tb/tb_div_seq.sv
// -----------------------------------------------------------------------------
// tb_div_seq : self-checking bench for div_seq (WIDTH = 32).
// Expected results are computed from 64-bit integer arithmetic and queued when
// an operation is issued. They are popped and compared once ready_o is seen.
// -----------------------------------------------------------------------------
module tb_div_seq;

  logic        clk;
  logic        resetn;
  logic        start_i;
  logic        signed_i;
  logic        annul_i;
  logic [31:0] opa_i;
  logic [31:0] opb_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_o;

  int n_checks;
  int n_fail;

  logic [63:0] exp_q[$];
  int          lat_q[$];

  div_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start_i  (start_i),
    .signed_i (signed_i),
    .annul_i  (annul_i),
    .opa_i    (opa_i),
    .opb_i    (opb_i),
    .result_o (result_o),
    .ready_o  (ready_o),
    .stall_o  (stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference {HI = remainder, LO = quotient}; divide-by-zero gives 0.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    longint x, y, q, r;
    logic [63:0] qv, rv;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q  = x / y;
    r  = x % y;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  function automatic logic [31:0] absv(input logic [31:0] x, input logic sgn);
    if (sgn && x[31]) return -x;
    return x;
  endfunction

  // Edges after the start edge until ready_o is visible.
  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b,
                                 input logic sgn);
    if (b == 32'd0) return 2;
`ifdef DIV_SEQ_EARLY_EXIT_EN
    if (absv(a, sgn) < absv(b, sgn)) return 1;
`endif
    return 32;
  endfunction

  // Issue one operation, queue its expectation, wait (bounded) for ready_o.
  // Operands are scrambled after the start edge to show they are ignored.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       output int lat, output logic [63:0] res, output int stall_err);
    exp_q.push_back(model(a, b, sgn));
    lat_q.push_back(exp_lat(a, b, sgn));
    @(negedge clk);
    start_i  = 1'b1;
    signed_i = sgn;
    opa_i    = a;
    opb_i    = b;
    @(posedge clk); #1;
    lat       = 0;
    stall_err = 0;
    while (ready_o !== 1'b1 && lat < 200) begin
      if (stall_o !== 1'b1) stall_err++;
      @(negedge clk);
      opa_i    = $urandom;
      opb_i    = $urandom;
      signed_i = ~sgn;
      @(posedge clk); #1;
      lat++;
    end
    res = result_o;
  endtask

  task automatic drop_start();
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  // Compare one completed operation against the head of the scoreboard.
  task automatic op_and_check(input string name, input logic [31:0] a,
                              input logic [31:0] b, input logic sgn);
    int lat, serr, elat;
    logic [63:0] res, exp;
    do_op(a, b, sgn, lat, res, serr);
    exp  = exp_q.pop_front();
    elat = lat_q.pop_front();
    n_checks++;
    if (res !== exp) begin
      n_fail++;
      $display("FAIL %s result: got %h expected %h", name, res, exp);
    end
    n_checks++;
    if (lat !== elat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, elat);
    end
    n_checks++;
    if (serr !== 0) begin
      n_fail++;
      $display("FAIL %s stall_busy: %0d cycles low, expected 0", name, serr);
    end
    n_checks++;
    if (stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s stall_at_ready: got %b expected 0", name, stall_o);
    end
    drop_start();
    n_checks++;
    if (ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s ready_after_release: got %b expected 0", name, ready_o);
    end
  endtask

  task automatic test_reset();
    start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
    opa_i = 32'd0; opb_i = 32'd0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (ready_o !== 1'b0) begin n_fail++; $display("FAIL reset ready: got %b expected 0", ready_o); end
    n_checks++;
    if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset stall: got %b expected 0", stall_o); end
    n_checks++;
    if (result_o !== 64'd0) begin n_fail++; $display("FAIL reset result: got %h expected 0", result_o); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_divu();
    int lat, serr;
    logic [63:0] res, exp;
    do_op(32'd100, 32'd7, 1'b0, lat, res, serr);
    exp = exp_q.pop_front();
    void'(lat_q.pop_front());
    n_checks++;
    if (res !== {32'h2, 32'hE}) begin n_fail++; $display("FAIL divu100_7 result: got %h expected %h", res, {32'h2, 32'hE}); end
    n_checks++;
    if (res !== exp) begin n_fail++; $display("FAIL divu100_7 model: got %h expected %h", res, exp); end
    n_checks++;
    if (lat !== 32) begin n_fail++; $display("FAIL divu100_7 latency: got %0d expected 32", lat); end
    n_checks++;
    if (serr !== 0) begin n_fail++; $display("FAIL divu100_7 stall_busy: %0d low cycles", serr); end
    // Held in END while start_i stays high.
    @(posedge clk); #1;
    n_checks++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL divu100_7 ready_hold: got %b expected 1", ready_o); end
    drop_start();
    n_checks++;
    if (ready_o !== 1'b0) begin n_fail++; $display("FAIL divu100_7 idle_after_release: got %b expected 0", ready_o); end
    n_checks++;
    if (result_o !== {32'h2, 32'hE}) begin n_fail++; $display("FAIL divu100_7 result_held: got %h expected %h", result_o, {32'h2, 32'hE}); end
  endtask

  task automatic test_div_signed();
    op_and_check("div_m7_2", 32'hFFFFFFF9, 32'h2, 1'b1);
    op_and_check("div_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1);
    op_and_check("div_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1);
    op_and_check("div_m100_m7", 32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1);
    op_and_check("divu_big", 32'hFFFFFFF9, 32'h2, 1'b0);
  endtask

  task automatic test_byzero();
    op_and_check("divu_5_0", 32'd5, 32'd0, 1'b0);
    op_and_check("div_m3_0", 32'hFFFFFFFD, 32'd0, 1'b1);
  endtask

  task automatic test_annul();
    int seen;
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; opa_i = 32'd1000; opb_i = 32'd3;
    @(posedge clk);                      // edge 0
    repeat (9) @(posedge clk);           // edges 1..9
    @(negedge clk);
    annul_i = 1'b1;
    #1;
    n_checks++;
    if (stall_o !== 1'b0) begin n_fail++; $display("FAIL annul stall: got %b expected 0", stall_o); end
    @(posedge clk); #1;                  // edge 10 aborts
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready_o === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL annul no_ready: ready seen %0d cycles, expected 0", seen); end
    n_checks++;
    if (stall_o !== 1'b0) begin n_fail++; $display("FAIL annul idle_stall: got %b expected 0", stall_o); end
    op_and_check("after_annul_50_5", 32'd50, 32'd5, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; opa_i = 32'd1000; opb_i = 32'd3;
    @(posedge clk);
    repeat (15) @(posedge clk);
    #1;
    resetn  = 1'b0;
    start_i = 1'b0;
    #1;
    n_checks++;
    if (ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid ready: got %b expected 0", ready_o); end
    n_checks++;
    if (result_o !== 64'd0) begin n_fail++; $display("FAIL rst_mid result: got %h expected 0", result_o); end
    @(negedge clk);
    resetn = 1'b1;
    op_and_check("post_rst_9_3", 32'd9, 32'd3, 1'b0);
  endtask

  task automatic test_early_exit();
    op_and_check("divu_5_9", 32'd5, 32'd9, 1'b0);
    op_and_check("div_m5_9", 32'hFFFFFFFB, 32'd9, 1'b1);
    op_and_check("divu_0_7", 32'd0, 32'd7, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic        s;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i % 3 == 0) ? ($urandom & 32'h000000FF) : $urandom;
      s = i[0];
      op_and_check("b2b_rand", a, b, s);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_divu();
    test_div_signed();
    test_byzero();
    test_annul();
    test_reset_mid();
    test_early_exit();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
